// File: rtl/sram_access_controller_if.sv
// rtl/sram_access_controller_if.sv - MEM-stage request/response bundle for the SRAM access controller
interface sram_access_controller_if;
    logic        read_en;
    logic        write_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output read_en,
        output write_en,
        output address,
        output write_data,
        input  read_data,
        input  ready
    );

    modport slave (
        input  read_en,
        input  write_en,
        input  address,
        input  write_data,
        output read_data,
        output ready
    );
endinterface

// File: rtl/sram_access_controller.sv
// rtl/sram_access_controller.sv - sequences 32-bit MEM-stage accesses onto a 16-bit asynchronous SRAM
module sram_access_controller #(
    parameter int ADDR_OFFSET   = 1024,
    parameter int ACCESS_CYCLES = 6,
    parameter int SRAM_ADDR_W   = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_access_controller_if.slave bus,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    input  logic [15:0]            sram_dq_in,
    output logic [15:0]            sram_dq_out,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n,
    output logic                   sram_oe_n,
    output logic                   sram_ce_n,
    output logic                   sram_ub_n,
    output logic                   sram_lb_n
);
    // One SRAM address bit selects the half-word, the rest is the word index.
    localparam int WORD_W = SRAM_ADDR_W - 1;
    // The wait counter is loaded with ACCESS_CYCLES-4 and counts down to zero.
    localparam int CNT_W  = (ACCESS_CYCLES > 4) ? $clog2(ACCESS_CYCLES - 3) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        HIGH,
        WAIT,
        DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              op_write;
    logic [WORD_W-1:0] word_q;
    logic [31:0]       data_q;
    logic [15:0]       staging;
    logic [31:0]       read_data_q;
    logic              request;
    logic [WORD_W-1:0] req_word;

    // Chip, upper and lower byte selects are permanently active.
    assign sram_ce_n = 1'b0;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;

    assign request = bus.read_en | bus.write_en;

    // Word index of the incoming request; upper bits beyond the SRAM size wrap silently.
    assign req_word = WORD_W'((bus.address - 32'(ADDR_OFFSET)) >> 2);

    // Pipeline may advance only in DONE or when nothing is being requested in IDLE.
    assign bus.ready = (state == DONE) || ((state == IDLE) && !request);

    assign bus.read_data = read_data_q;

    // Access sequencer: state, latched request and registered SRAM pin drive.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            op_write    <= 1'b0;
            word_q      <= '0;
            data_q      <= '0;
            staging     <= '0;
            read_data_q <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        // Write takes priority when both enables are raised together.
                        op_write   <= bus.write_en;
                        word_q     <= req_word;
                        data_q     <= bus.write_data;
                        sram_addr  <= {req_word, 1'b0};
                        if (bus.write_en) begin
                            sram_dq_out <= bus.write_data[15:0];
                        end
                        sram_we_n  <= !bus.write_en;
                        sram_dq_oe <= bus.write_en;
                        sram_oe_n  <= bus.write_en;
                        state      <= LOW;
                    end
                end
                LOW: begin
                    if (!op_write) begin
                        staging <= sram_dq_in;
                    end else begin
                        sram_dq_out <= data_q[31:16];
                    end
                    sram_addr <= {word_q, 1'b1};
                    state     <= HIGH;
                end
                HIGH: begin
                    if (!op_write) begin
                        read_data_q <= {sram_dq_in, staging};
                    end
                    sram_we_n  <= 1'b1;
                    sram_oe_n  <= 1'b1;
                    sram_dq_oe <= 1'b0;
                    if (ACCESS_CYCLES > 3) begin
                        wait_cnt <= CNT_W'(ACCESS_CYCLES - 4);
                        state    <= WAIT;
                    end else begin
                        state <= DONE;
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sram_access_controller.sv
// tb/tb_sram_access_controller.sv - self-checking bench for sram_access_controller
module tb_sram_access_controller;
    localparam int AW = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        tb_re, tb_we, sel;
    logic [31:0] tb_addr, tb_wdata;
    logic [15:0] sram_dq_in;

    sram_access_controller_if bus6();
    sram_access_controller_if bus3();

    logic [AW-1:0] addr6, addr3;
    logic [15:0]   dqo6, dqo3;
    logic          dqoe6, dqoe3, we6, we3, oen6, oen3;
    logic          ce6, ce3, ub6, ub3, lb6, lb3;

    assign bus6.read_en    = tb_re & ~sel;
    assign bus6.write_en   = tb_we & ~sel;
    assign bus6.address    = tb_addr;
    assign bus6.write_data = tb_wdata;
    assign bus3.read_en    = tb_re & sel;
    assign bus3.write_en   = tb_we & sel;
    assign bus3.address    = tb_addr;
    assign bus3.write_data = tb_wdata;

    sram_access_controller #(.ADDR_OFFSET(1024), .ACCESS_CYCLES(6), .SRAM_ADDR_W(AW)) dut (
        .clk(clk), .rst(rst_n), .bus(bus6.slave),
        .sram_addr(addr6), .sram_dq_in(sram_dq_in), .sram_dq_out(dqo6), .sram_dq_oe(dqoe6),
        .sram_we_n(we6), .sram_oe_n(oen6), .sram_ce_n(ce6), .sram_ub_n(ub6), .sram_lb_n(lb6)
    );

    sram_access_controller #(.ADDR_OFFSET(1024), .ACCESS_CYCLES(3), .SRAM_ADDR_W(AW)) dut3 (
        .clk(clk), .rst(rst_n), .bus(bus3.slave),
        .sram_addr(addr3), .sram_dq_in(sram_dq_in), .sram_dq_out(dqo3), .sram_dq_oe(dqoe3),
        .sram_we_n(we3), .sram_oe_n(oen3), .sram_ce_n(ce3), .sram_ub_n(ub3), .sram_lb_n(lb3)
    );

    wire          s_ready = sel ? bus3.ready : bus6.ready;
    wire [31:0]   s_rd    = sel ? bus3.read_data : bus6.read_data;
    wire [AW-1:0] s_addr  = sel ? addr3 : addr6;
    wire [15:0]   s_dqo   = sel ? dqo3 : dqo6;
    wire          s_dqoe  = sel ? dqoe3 : dqoe6;
    wire          s_we_n  = sel ? we3 : we6;
    wire          s_oe_n  = sel ? oen3 : oen6;

    // Asynchronous SRAM model shared by whichever controller is selected.
    bit [15:0] mem [0:(1<<AW)-1];
    always @(negedge clk) begin
        if (!s_we_n && s_dqoe) mem[s_addr] <= s_dqo;
        sram_dq_in <= s_oe_n ? 16'h0000 : mem[s_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full access; called at posedge+1, returns at posedge+1 after DONE with enables dropped.
    task automatic do_access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] exp_rd, input logic [AW-1:0] exp_lo, input bit scramble);
        int lows = 0;
        int we_cnt = 0;
        int oe_cnt = 0;
        bit late_strobe = 0;
        bit done = 0;
        int acc = sel ? 3 : 6;
        tb_we = w; tb_re = r; tb_addr = a; tb_wdata = d;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (s_ready) begin
                done = 1;
            end else begin
                lows++;
                if (i == 1) begin
                    check("low_addr", 32'(s_addr), 32'(exp_lo));
                    if (w) check("low_dq_out", 32'(s_dqo), 32'(d[15:0]));
                end
                if (i == 2) begin
                    check("high_addr", 32'(s_addr), 32'(exp_lo + 18'd1));
                    if (w) check("high_dq_out", 32'(s_dqo), 32'(d[31:16]));
                end
            end
            if (!s_we_n) we_cnt++;
            if (!s_oe_n) oe_cnt++;
            if (i >= 3 && (!s_we_n || !s_oe_n || s_dqoe)) late_strobe = 1;
            if (scramble && i >= 1) begin
                tb_addr = $urandom;
                tb_wdata = $urandom;
            end
        end
        check("ready_low_cycles", lows, acc);
        check("read_data_at_done", s_rd, exp_rd);
        check("we_strobe_cycles", we_cnt, w ? 2 : 0);
        check("oe_strobe_cycles", oe_cnt, (!w && r) ? 2 : 0);
        check("late_strobe", 32'(late_strobe), 32'd0);
        @(posedge clk); #1;
        tb_we = 0; tb_re = 0;
    endtask

    typedef struct {
        logic          w;
        logic          r;
        logic [31:0]   a;
        logic [31:0]   d;
        logic [31:0]   exp_rd;
        logic [AW-1:0] exp_lo;
    } vec_t;

    vec_t vt[8];
    logic [31:0] ref_mem [int];
    logic [31:0] last_rd;

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        vt[0] = '{1'b1, 1'b0, 32'd1028,   32'hDEADBEEF, 32'h00000000, 18'd2};
        vt[1] = '{1'b0, 1'b1, 32'd1028,   32'h00000000, 32'hDEADBEEF, 18'd2};
        vt[2] = '{1'b1, 1'b0, 32'd1032,   32'hCAFEF00D, 32'hDEADBEEF, 18'd4};
        vt[3] = '{1'b0, 1'b1, 32'd1033,   32'h00000000, 32'hCAFEF00D, 18'd4};
        vt[4] = '{1'b1, 1'b1, 32'd1024,   32'h12345678, 32'hCAFEF00D, 18'd0};
        vt[5] = '{1'b0, 1'b1, 32'd1024,   32'h00000000, 32'h12345678, 18'd0};
        vt[6] = '{1'b1, 1'b0, 32'd1020,   32'hA5A55A5A, 32'h12345678, 18'h3FFFE};
        vt[7] = '{1'b0, 1'b1, 32'd525308, 32'h00000000, 32'hA5A55A5A, 18'h3FFFE};

        rst_n = 0; tb_re = 0; tb_we = 0; tb_addr = 0; tb_wdata = 0; sel = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(s_ready), 32'd1);
        check("rst_we_n", 32'(s_we_n), 32'd1);
        check("rst_oe_n", 32'(s_oe_n), 32'd1);
        check("rst_dq_oe", 32'(s_dqoe), 32'd0);
        check("rst_sram_addr", 32'(s_addr), 32'd0);
        check("rst_dq_out", 32'(s_dqo), 32'd0);
        check("rst_read_data", s_rd, 32'd0);
        check("tied_ce_ub_lb", {29'd0, ce6, ub6, lb6}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        check("idle_ready", 32'(s_ready), 32'd1);
        @(posedge clk); #1;

        // Directed table, applied back to back.
        for (int i = 0; i < 8; i++)
            do_access(vt[i].w, vt[i].r, vt[i].a, vt[i].d, vt[i].exp_rd, vt[i].exp_lo, 1'b0);

        // Latency of a read followed by an idle cycle.
        do_access(1'b0, 1'b1, 32'd1028, 32'd0, 32'hDEADBEEF, 18'd2, 1'b0);
        @(negedge clk);
        check("idle_after_done", 32'(s_ready), 32'd1);
        @(posedge clk); #1;

        // Asynchronous reset while a write is in its HIGH half.
        tb_we = 1; tb_re = 0; tb_addr = 32'd1024 + 32'd400; tb_wdata = 32'h11112222;
        repeat (3) @(negedge clk);
        check("mid_we_n_active", 32'(s_we_n), 32'd0);
        #2 rst_n = 0;
        #1;
        check("mid_rst_we_n", 32'(s_we_n), 32'd1);
        check("mid_rst_dq_oe", 32'(s_dqoe), 32'd0);
        check("mid_rst_read_data", s_rd, 32'd0);
        tb_we = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        check("post_rst_ready", 32'(s_ready), 32'd1);
        @(posedge clk); #1;

        // Randomized accesses against a word-level memory model.
        last_rd = 32'd0;
        for (int n = 0; n < 60; n++) begin
            int unsigned k;
            logic w, r;
            logic [31:0] a, d, exp;
            int gap;
            k = $urandom_range(16, 47);
            a = 32'd1024 + 4 * k + $urandom_range(0, 3);
            d = $urandom;
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            if (!w && !r) r = 1;
            if (w) begin
                ref_mem[int'(k)] = d;
                exp = last_rd;
            end else begin
                exp = ref_mem.exists(int'(k)) ? ref_mem[int'(k)] : 32'd0;
                last_rd = exp;
            end
            do_access(w, r, a, d, exp, AW'(2 * k), 1'b1);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                check("gap_ready", 32'(s_ready), 32'd1);
                @(posedge clk); #1;
            end
        end

        // Minimum-latency instance.
        sel = 1;
        do_access(1'b1, 1'b0, 32'd1024 + 32'd800, 32'h0BADF00D, 32'd0, 18'd400, 1'b0);
        do_access(1'b0, 1'b1, 32'd1024 + 32'd800, 32'd0, 32'h0BADF00D, 18'd400, 1'b0);
        do_access(1'b0, 1'b1, 32'd1028, 32'd0, 32'hDEADBEEF, 18'd2, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
